axis_endian_converter: RTL and testbench

//  Parametrised AXI4-Stream byte-order converter placed between little-endian IP (DMA, MAC wrappers) and big-endian datapath modules.

---
 rtl/endian_conv_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 62 ++++++
 rtl/axis_endian_converter.sv | 157 +++++++++++++++
 tb/tb_axis_endian_converter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/endian_conv_pkg.sv
// Shared definitions for the AXI4-Stream endian converter.
// Holds swap-mode codes, the packet FSM encoding and a byte-source helper.
// Build option: ENDIAN_CONV_STATS_EN (consumed by the top level only).
package endian_conv_pkg;

  localparam logic [1:0] SWAP_BYPASS     = 2'd0;
  localparam logic [1:0] SWAP_FULL       = 2'd1;
  localparam logic [1:0] SWAP_IN_WORD    = 2'd2;
  localparam logic [1:0] SWAP_WORD_ORDER = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  // Index of the input byte that lands on output byte idx for a given mode.
  function automatic int unsigned src_byte(input logic [1:0] mode,
                                           input int unsigned idx,
                                           input int unsigned nbytes,
                                           input int unsigned wbytes);
    int unsigned word_idx;
    int unsigned byte_in_word;
    word_idx     = idx / wbytes;
    byte_in_word = idx % wbytes;
    case (mode)
      SWAP_FULL:       return nbytes - 1 - idx;
      SWAP_IN_WORD:    return word_idx * wbytes + (wbytes - 1 - byte_in_word);
      SWAP_WORD_ORDER: return ((nbytes / wbytes) - 1 - word_idx) * wbytes + byte_in_word;
      default:         return idx;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: output register plus one skid register.
// Latency: 1 cycle from accept to m_valid; 1 beat/clk sustained.
// Backpressure: s_ready is registered (= !skid occupied), never combinational on m_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             out_free;
  logic             skid_next;

  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  // Skid register is occupied next cycle only if the output is stuck and something is (or was) parked.
  always_comb begin
    skid_next = 1'b0;
    if (!out_free) begin
      skid_next = skid_valid || accept;
    end
  end

  // Output/skid register updates; ready tracks the future skid occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          m_valid    <= 1'b1;
          m_data     <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
      s_ready <= !skid_next;
    end
  end

endmodule

// File: rtl/axis_endian_converter.sv
// AXI4-Stream byte-order converter with per-packet latched swap mode.
// Latency: 1 cycle accept-to-output, 1 beat/clk; conversion done before storage.
// Backpressure: 2-entry skid; s_axis_tready registered. Option: ENDIAN_CONV_STATS_EN adds counters.
module axis_endian_converter
  import endian_conv_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int WORD_BYTES         = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      swap_mode,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef ENDIAN_CONV_STATS_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     beat_count
`endif
);

  localparam int DW     = C_AXIS_DATA_WIDTH;
  localparam int UW     = C_AXIS_TUSER_WIDTH;
  localparam int NBYTES = DW / 8;
  localparam int PW     = 1 + UW + NBYTES + DW;

  if ((DW % 8) != 0) begin : g_bad_dw
    $error("C_AXIS_DATA_WIDTH must be a multiple of 8");
  end
  if ((WORD_BYTES <= 0) || ((NBYTES % WORD_BYTES) != 0)) begin : g_bad_word
    $error("WORD_BYTES must divide C_AXIS_DATA_WIDTH/8");
  end

  pkt_state_t       state;
  pkt_state_t       state_next;
  logic [1:0]       mode_q;
  logic [1:0]       mode_next;
  logic [1:0]       eff_mode;
  logic             accept;
  logic [DW-1:0]    data_conv;
  logic [NBYTES-1:0] strb_conv;
  logic [PW-1:0]    s_payload;
  logic [PW-1:0]    m_payload;

  assign accept = s_axis_tvalid && s_axis_tready;

  // Mode latch: first beat of a packet samples swap_mode, later beats reuse it.
  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    eff_mode   = mode_q;
    case (state)
      ST_IDLE: begin
        eff_mode = swap_mode;
        if (accept) begin
          mode_next  = swap_mode;
          state_next = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
        end
      end
      ST_IN_PKT: begin
        if (accept && s_axis_tlast) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Packet FSM and latched mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= SWAP_BYPASS;
    end else begin
      state  <= state_next;
      mode_q <= mode_next;
    end
  end

  // Byte permutation network: each output byte picks from four fixed sources.
  for (genvar i = 0; i < NBYTES; i++) begin : g_perm
    localparam int unsigned SRC_FULL = src_byte(SWAP_FULL, i, NBYTES, WORD_BYTES);
    localparam int unsigned SRC_WORD = src_byte(SWAP_IN_WORD, i, NBYTES, WORD_BYTES);
    localparam int unsigned SRC_ORD  = src_byte(SWAP_WORD_ORDER, i, NBYTES, WORD_BYTES);

    logic [7:0] byte_sel;
    logic       strb_sel;

    // Select this output byte (and its strobe) by the active mode.
    always_comb begin
      byte_sel = s_axis_tdata[i*8 +: 8];
      strb_sel = s_axis_tstrb[i];
      case (eff_mode)
        SWAP_FULL: begin
          byte_sel = s_axis_tdata[SRC_FULL*8 +: 8];
          strb_sel = s_axis_tstrb[SRC_FULL];
        end
        SWAP_IN_WORD: begin
          byte_sel = s_axis_tdata[SRC_WORD*8 +: 8];
          strb_sel = s_axis_tstrb[SRC_WORD];
        end
        SWAP_WORD_ORDER: begin
          byte_sel = s_axis_tdata[SRC_ORD*8 +: 8];
          strb_sel = s_axis_tstrb[SRC_ORD];
        end
        default: ;
      endcase
    end

    assign data_conv[i*8 +: 8] = byte_sel;
    assign strb_conv[i]        = strb_sel;
  end

  assign s_payload = {s_axis_tlast, s_axis_tuser, strb_conv, data_conv};

  axis_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_data  (s_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (m_payload)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = m_payload;

`ifdef ENDIAN_CONV_STATS_EN
  // Output-side transfer counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      beat_count <= beat_count + 32'd1;
      if (m_axis_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_endian_converter.sv
// Self-checking bench for axis_endian_converter (DW=64, WORD_BYTES=4).
// Directed steps plus random traffic checked against a streaming-operator model.
// Honors ENDIAN_CONV_STATS_EN when defined.
module tb_axis_endian_converter;

  localparam int DW = 64;
  localparam int UW = 8;
  localparam logic [63:0] PAT = 64'h0011223344556677;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  swap_mode;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tstrb;
  logic [7:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
`ifdef ENDIAN_CONV_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] beat_count;
`endif

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  logic  model_in_pkt = 1'b0;
  logic [1:0] model_mode = 2'd0;
  logic  last_acc;
  logic  last_drn;
  int    acc_cnt;
  int    drn_cnt;
  int    tb_beats = 0;
  int    tb_pkts = 0;

  always #5 clk = ~clk;

  axis_endian_converter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .WORD_BYTES         (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .swap_mode     (swap_mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef ENDIAN_CONV_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .beat_count    (beat_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected conversion expressed with streaming operators on whole beats.
  function automatic beat_t convert(input beat_t b, input logic [1:0] mode);
    beat_t r;
    logic [63:0] drev;
    logic [7:0]  srev;
    r    = b;
    drev = {<<8{b.data}};
    srev = {<<{b.strb}};
    case (mode)
      2'd1: begin r.data = drev;               r.strb = srev;               end
      2'd2: begin r.data = {<<32{drev}};       r.strb = {<<4{srev}};        end
      2'd3: begin r.data = {<<32{b.data}};     r.strb = {<<4{b.strb}};      end
      default: ;
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, score the transfers that the next posedge performs.
  task automatic step(input logic vld, input logic [63:0] d, input logic [7:0] st,
                      input logic [7:0] u, input logic l, input logic [1:0] md, input logic mr);
    beat_t b;
    beat_t e;
    logic [1:0] use_mode;
    @(negedge clk);
    s_axis_tvalid = vld;
    s_axis_tdata  = d;
    s_axis_tstrb  = st;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    swap_mode     = md;
    m_axis_tready = mr;
    last_acc = vld && s_axis_tready;
    last_drn = m_axis_tvalid && mr;
    if (last_drn) begin
      tb_beats++;
      if (m_axis_tlast) tb_pkts++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_tdata", m_axis_tdata, e.data);
        check("sb_tstrb", {56'd0, m_axis_tstrb}, {56'd0, e.strb});
        check("sb_tuser", {56'd0, m_axis_tuser}, {56'd0, e.user});
        check("sb_tlast", {63'd0, m_axis_tlast}, {63'd0, e.last});
      end
    end
    if (last_acc) begin
      use_mode = model_in_pkt ? model_mode : md;
      if (!model_in_pkt) model_mode = md;
      model_in_pkt = !l;
      b.data = d; b.strb = st; b.user = u; b.last = l;
      exp_q.push_back(convert(b, use_mode));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 64'd0, 8'd0, 8'd0, 1'b0, 2'd0, 1'b1);
  endtask

  // Single-beat packet, then check the literal result one cycle later.
  task automatic single(input logic [1:0] md, input logic [63:0] exp_d, input logic [7:0] exp_s, input string tag);
    step(1'b1, PAT, 8'h0F, 8'hA5, 1'b1, md, 1'b1);
    check({tag, "_accepted"}, {63'd0, last_acc}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd1);
    check({tag, "_tdata"}, m_axis_tdata, exp_d);
    check({tag, "_tstrb"}, {56'd0, m_axis_tstrb}, {56'd0, exp_s});
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    swap_mode = 2'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("tready_after_rst", {63'd0, s_axis_tready}, 64'd1);

    // Each mode on the reference beat
    single(2'd1, 64'h7766554433221100, 8'hF0, "mode1");
    single(2'd2, 64'h3322110077665544, 8'h0F, "mode2");
    single(2'd3, 64'h4455667700112233, 8'hF0, "mode3");
    single(2'd0, PAT, 8'h0F, "mode0");

    // Mode switch mid-packet is ignored; next packet picks up the new mode
    step(1'b1, 64'h0102030405060708, 8'hFF, 8'h01, 1'b0, 2'd1, 1'b1);
    step(1'b1, 64'h1112131415161718, 8'hFF, 8'h02, 1'b0, 2'd0, 1'b1);
    step(1'b1, 64'h2122232425262728, 8'h3C, 8'h03, 1'b1, 2'd0, 1'b1);
    step(1'b1, 64'h3132333435363738, 8'h81, 8'h04, 1'b1, 2'd0, 1'b1);
    idle(3);

    // Backpressure: stall 5 cycles during a stream
    acc_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, {$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'b0, 2'd2, 1'b0);
      if (last_acc) acc_cnt++;
    end
    check("stall_accepted", 64'(acc_cnt), 64'd2);
    @(posedge clk); #1;
    check("stall_tready", {63'd0, s_axis_tready}, 64'd0);
    drn_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, {$urandom, $urandom}, 8'($urandom), 8'($urandom), k == 5, 2'd0, 1'b1);
      if (last_drn) drn_cnt++;
    end
    check("release_rate", 64'(drn_cnt), 64'd6);
    idle(4);
    check("stall_no_loss", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a mode-3 packet
    step(1'b1, 64'hDEADBEEFCAFEF00D, 8'hFF, 8'h11, 1'b0, 2'd3, 1'b1);
    step(1'b1, 64'h0123456789ABCDEF, 8'hFF, 8'h22, 1'b0, 2'd3, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    check("midrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    check("midrst_tstrb", {56'd0, m_axis_tstrb}, 64'd0);
    check("midrst_tuser", {56'd0, m_axis_tuser}, 64'd0);
    check("midrst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("midrst_tready", {63'd0, s_axis_tready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_in_pkt = 1'b0;
    tb_beats = 0;
    tb_pkts = 0;
    idle(1);
    single(2'd2, 64'h3322110077665544, 8'h0F, "post_rst");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 8'($urandom), 8'($urandom),
           $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 9) < 7);
    end
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) idle(1);
    idle(1);
    check("final_drain", 64'(exp_q.size()), 64'd0);

`ifdef ENDIAN_CONV_STATS_EN
    check("beat_count", {32'd0, beat_count}, 64'(tb_beats));
    check("pkt_count", {32'd0, pkt_count}, 64'(tb_pkts));
    @(negedge clk);
    force dut.beat_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.beat_count;
    step(1'b1, PAT, 8'hFF, 8'h00, 1'b1, 2'd0, 1'b1);
    idle(2);
    check("beat_count_wrap", {32'd0, beat_count}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
